// File: rtl/evt_ts_pkg.sv
// Shared definitions for the event timestamp unit: register map, CTRL fields, FIFO entry type.
package evt_ts_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_TS_HI  = 3'd2;
    localparam logic [2:0] REG_TS_LO  = 3'd3;
    localparam logic [2:0] REG_HEAD   = 3'd4;

    localparam int unsigned CTRL_CH_EN_LSB = 0;
    localparam int unsigned CTRL_POL_LSB   = 4;
    localparam int unsigned CTRL_IRQ_EN    = 8;
    localparam int unsigned CTRL_CLEAR     = 15;

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] ts;
    } evt_entry_t;

    function automatic logic [1:0] first_set(input logic [3:0] v);
        first_set = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) first_set = 2'(i);
        end
    endfunction

endpackage

// File: rtl/evt_ts_fifo.sv
// Synchronous FIFO of evt_entry_t with clear and a registered show-ahead head.
module evt_ts_fifo
    import evt_ts_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  evt_entry_t i_data,
    input  logic       i_pop,
    input  logic       i_clear,
    output evt_entry_t o_head,
    output logic       o_full,
    output logic       o_empty,
    output logic [AW:0] o_count
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    evt_entry_t      r_mem [DEPTH];
    evt_entry_t      r_head;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_do_pop;
    logic            w_do_push;
    logic [AW-1:0]   w_rd_next;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~w_empty & ~i_clear;
    assign w_do_push = i_push & ~i_clear & (~w_full | w_do_pop);
    assign w_rd_next = w_do_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rd_ptr <= w_rd_next;
            if (w_do_push && !w_do_pop) r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
            // Prefetch next head; bypass when the incoming entry lands in the head slot
            if (w_do_push && (r_wr_ptr == w_rd_next)) r_head <= i_data;
            else r_head <= r_mem[w_rd_next];
        end
    end

    assign o_head  = r_head;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/evt_timestamp_unit.sv
// Timestamps edges on four async event lines into a CPU-readable FIFO.
// Optional input debounce filter enabled by defining EVT_TS_DEBOUNCE_EN.
module evt_timestamp_unit
    import evt_ts_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = $clog2(DEPTH),
    parameter int unsigned DEBOUNCE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] tick_in,
    input  logic [3:0]  evt_in,
    input  logic        cs,
    input  logic [1:0]  wr,
    input  logic [2:0]  address,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        irq
);

    if ((DEPTH < 4) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0) || (DEBOUNCE == 0))
    begin : g_param_check
        $error("evt_timestamp_unit: DEPTH must be a power of two in 4..256, DEBOUNCE > 0");
    end

    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [3:0]  r_prev;
    logic [3:0]  r_pending;
    logic [31:0] r_ts [4];
    logic [8:0]  r_ctrl;
    logic        r_overflow;
    logic        r_bus_act;

    logic [3:0]  w_level;
    logic [3:0]  w_pol;
    logic [3:0]  w_accept;
    logic [3:0]  w_capture;
    logic [3:0]  w_dup;
    logic [3:0]  w_grant;
    logic [1:0]  w_grant_idx;
    logic        w_push;
    logic        w_drop;
    logic        w_bus_act;
    logic        w_wr_stb;
    logic        w_ctrl_wr;
    logic        w_clear;
    logic        w_pop;
    evt_entry_t  w_push_data;
    evt_entry_t  w_head;
    logic        w_full;
    logic        w_empty;
    logic [AW:0] w_count;
    logic [15:0] w_dout;
    logic        w_unused_din;

    assign w_unused_din = ^din[14:9];

`ifdef EVT_TS_DEBOUNCE_EN
    localparam int unsigned DBW = $clog2(DEBOUNCE + 1);

    logic [DBW-1:0] r_db_cnt [4];
    logic [3:0]     r_filt;

    // Filtered level flips only after DEBOUNCE consecutive cycles at the new level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt <= '0;
            for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DBW'(DEBOUNCE - 1)) begin
                    r_filt[i]   <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync2;
`endif

    assign w_pol     = r_ctrl[CTRL_POL_LSB +: 4];
    assign w_accept  = r_ctrl[CTRL_CH_EN_LSB +: 4]
                     & (((w_level & ~r_prev) & ~w_pol) | ((~w_level & r_prev) & w_pol));
    assign w_capture = w_accept & ~r_pending;
    assign w_dup     = w_accept & r_pending;

    assign w_bus_act = cs & (|wr);
    assign w_wr_stb  = w_bus_act & ~r_bus_act;
    assign w_ctrl_wr = w_wr_stb & (address == REG_CTRL);
    assign w_clear   = w_ctrl_wr & wr[1] & din[CTRL_CLEAR];
    assign w_pop     = w_wr_stb & (address == REG_HEAD);

    assign w_grant     = r_pending & (~r_pending + 4'd1);
    assign w_grant_idx = first_set(r_pending);
    assign w_push      = |r_pending;
    assign w_push_data = '{ch: w_grant_idx, ts: r_ts[w_grant_idx]};
    assign w_drop      = w_push & w_full & ~w_pop & ~w_clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_prev     <= '0;
            r_pending  <= '0;
            r_ctrl     <= '0;
            r_overflow <= 1'b0;
            r_bus_act  <= 1'b0;
        end else begin
            r_sync1   <= evt_in;
            r_sync2   <= r_sync1;
            r_prev    <= w_level;
            r_bus_act <= w_bus_act;
            if (w_ctrl_wr && wr[0]) r_ctrl[7:0] <= din[7:0];
            if (w_ctrl_wr && wr[1]) r_ctrl[8]   <= din[CTRL_IRQ_EN];
            if (w_clear) begin
                r_pending  <= '0;
                r_overflow <= 1'b0;
            end else begin
                r_pending <= (r_pending & ~w_grant) | w_capture;
                if ((|w_dup) || w_drop) r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_ts[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_capture[i]) r_ts[i] <= tick_in;
            end
        end
    end

    evt_ts_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_dout = '0;
        if (cs && (wr == 2'b00) && !reset) begin
            case (address)
                REG_CTRL:   w_dout = {7'b0, r_ctrl};
                REG_STATUS: w_dout = {w_empty, r_overflow, w_full, 4'b0, 9'(w_count)};
                REG_TS_HI:  w_dout = w_head.ts[31:16];
                REG_TS_LO:  w_dout = w_head.ts[15:0];
                REG_HEAD:   w_dout = {w_empty, 13'b0, w_head.ch};
                default:    w_dout = '0;
            endcase
        end
    end

    assign dout = w_dout;
    assign irq  = ~w_empty & r_ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_evt_timestamp_unit.sv
// Directed, table-driven bench for evt_timestamp_unit (default build, DEPTH=16).
module tb_evt_timestamp_unit;
    import evt_ts_pkg::*;

    localparam logic [2:0] OP_WR   = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_EVT  = 3'd2;
    localparam logic [2:0] OP_TICK = 3'd3;
    localparam logic [2:0] OP_IRQ  = 3'd4;

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  addr;
        logic [1:0]  wr;
        logic [31:0] data;
        logic [15:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] tick_in;
    logic [3:0]  evt_in;
    logic        cs;
    logic [1:0]  wr;
    logic [2:0]  address;
    logic [15:0] din;
    logic [15:0] dout;
    logic        irq;

    int checks = 0;
    int errors = 0;

    evt_timestamp_unit #(
        .DEPTH    (16),
        .DEBOUNCE (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tick_in (tick_in),
        .evt_in  (evt_in),
        .cs      (cs),
        .wr      (wr),
        .address (address),
        .din     (din),
        .dout    (dout),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d, input logic [1:0] w);
        @(negedge clk);
        cs = 1'b1; wr = w; address = a; din = d;
        @(negedge clk);
        cs = 1'b0; wr = 2'b00;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 2'b00; address = a;
        #1 d = dout;
        cs = 1'b0;
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [2:0] a, input logic [1:0] w,
                                input logic [31:0] d, input logic [15:0] e);
        vec_t v;
        v.op = op; v.addr = a; v.wr = w; v.data = d; v.exp = e;
        return v;
    endfunction

    vec_t        vecs[$];
    logic [15:0] rd;

    initial begin
        // Basic capture, rising polarity
        vecs.push_back(mk(OP_WR,   REG_CTRL,   2'b11, 32'h000F, 16'h0));
        vecs.push_back(mk(OP_RD,   REG_CTRL,   2'b00, 32'h0,    16'h000F));
        vecs.push_back(mk(OP_TICK, 3'd0,       2'b00, 32'h00001234, 16'h0));
        vecs.push_back(mk(OP_EVT,  3'd0,       2'b00, 32'h1,    16'h0));
        vecs.push_back(mk(OP_RD,   REG_STATUS, 2'b00, 32'h0,    16'h0001));
        vecs.push_back(mk(OP_RD,   REG_TS_HI,  2'b00, 32'h0,    16'h0000));
        vecs.push_back(mk(OP_RD,   REG_TS_LO,  2'b00, 32'h0,    16'h1234));
        vecs.push_back(mk(OP_RD,   REG_HEAD,   2'b00, 32'h0,    16'h0000));
        vecs.push_back(mk(OP_WR,   REG_HEAD,   2'b11, 32'h0,    16'h0));
        vecs.push_back(mk(OP_RD,   REG_STATUS, 2'b00, 32'h0,    16'h8000));
        vecs.push_back(mk(OP_EVT,  3'd0,       2'b00, 32'h0,    16'h0));
        vecs.push_back(mk(OP_RD,   REG_STATUS, 2'b00, 32'h0,    16'h8000));
        // Falling polarity on ch0
        vecs.push_back(mk(OP_WR,   REG_CTRL,   2'b11, 32'h00F1, 16'h0));
        vecs.push_back(mk(OP_TICK, 3'd0,       2'b00, 32'h00005555, 16'h0));
        vecs.push_back(mk(OP_EVT,  3'd0,       2'b00, 32'h1,    16'h0));
        vecs.push_back(mk(OP_RD,   REG_STATUS, 2'b00, 32'h0,    16'h8000));
        vecs.push_back(mk(OP_TICK, 3'd0,       2'b00, 32'h00006666, 16'h0));
        vecs.push_back(mk(OP_EVT,  3'd0,       2'b00, 32'h0,    16'h0));
        vecs.push_back(mk(OP_RD,   REG_STATUS, 2'b00, 32'h0,    16'h0001));
        vecs.push_back(mk(OP_RD,   REG_TS_LO,  2'b00, 32'h0,    16'h6666));
        vecs.push_back(mk(OP_WR,   REG_HEAD,   2'b11, 32'h0,    16'h0));
        vecs.push_back(mk(OP_RD,   REG_STATUS, 2'b00, 32'h0,    16'h8000));
        // Four simultaneous edges drain in channel order
        vecs.push_back(mk(OP_WR,   REG_CTRL,   2'b11, 32'h000F, 16'h0));
        vecs.push_back(mk(OP_TICK, 3'd0,       2'b00, 32'hDEADBEEF, 16'h0));
        vecs.push_back(mk(OP_EVT,  3'd0,       2'b00, 32'hF,    16'h0));
        vecs.push_back(mk(OP_RD,   REG_STATUS, 2'b00, 32'h0,    16'h0004));
        for (int c = 0; c < 4; c++) begin
            vecs.push_back(mk(OP_RD, REG_HEAD,  2'b00, 32'h0, 16'(c)));
            vecs.push_back(mk(OP_RD, REG_TS_HI, 2'b00, 32'h0, 16'hDEAD));
            vecs.push_back(mk(OP_RD, REG_TS_LO, 2'b00, 32'h0, 16'hBEEF));
            vecs.push_back(mk(OP_WR, REG_HEAD,  2'b11, 32'h0, 16'h0));
        end
        vecs.push_back(mk(OP_RD,   REG_STATUS, 2'b00, 32'h0,    16'h8000));
        vecs.push_back(mk(OP_EVT,  3'd0,       2'b00, 32'h0,    16'h0));
        vecs.push_back(mk(OP_RD,   REG_STATUS, 2'b00, 32'h0,    16'h8000));
        // Byte lanes on CTRL
        vecs.push_back(mk(OP_WR,   REG_CTRL,   2'b01, 32'h01F3, 16'h0));
        vecs.push_back(mk(OP_RD,   REG_CTRL,   2'b00, 32'h0,    16'h00F3));
        vecs.push_back(mk(OP_WR,   REG_CTRL,   2'b10, 32'h0100, 16'h0));
        vecs.push_back(mk(OP_RD,   REG_CTRL,   2'b00, 32'h0,    16'h01F3));
        // irq and pop-on-empty
        vecs.push_back(mk(OP_WR,   REG_CTRL,   2'b11, 32'h0101, 16'h0));
        vecs.push_back(mk(OP_IRQ,  3'd0,       2'b00, 32'h0,    16'h0));
        vecs.push_back(mk(OP_EVT,  3'd0,       2'b00, 32'h1,    16'h0));
        vecs.push_back(mk(OP_RD,   REG_STATUS, 2'b00, 32'h0,    16'h0001));
        vecs.push_back(mk(OP_IRQ,  3'd0,       2'b00, 32'h0,    16'h1));
        vecs.push_back(mk(OP_WR,   REG_HEAD,   2'b11, 32'h0,    16'h0));
        vecs.push_back(mk(OP_IRQ,  3'd0,       2'b00, 32'h0,    16'h0));
        vecs.push_back(mk(OP_WR,   REG_HEAD,   2'b11, 32'h0,    16'h0));
        vecs.push_back(mk(OP_RD,   REG_STATUS, 2'b00, 32'h0,    16'h8000));
        vecs.push_back(mk(OP_EVT,  3'd0,       2'b00, 32'h0,    16'h0));
        vecs.push_back(mk(OP_TICK, 3'd0,       2'b00, 32'h0000AAAA, 16'h0));
        vecs.push_back(mk(OP_EVT,  3'd0,       2'b00, 32'h1,    16'h0));
        vecs.push_back(mk(OP_RD,   REG_STATUS, 2'b00, 32'h0,    16'h0001));
        vecs.push_back(mk(OP_RD,   REG_TS_LO,  2'b00, 32'h0,    16'hAAAA));
        vecs.push_back(mk(OP_RD,   REG_HEAD,   2'b00, 32'h0,    16'h0000));
        vecs.push_back(mk(OP_WR,   REG_HEAD,   2'b11, 32'h0,    16'h0));
        // Unmapped addresses
        vecs.push_back(mk(OP_RD,   3'd5,       2'b00, 32'h0,    16'h0000));
        vecs.push_back(mk(OP_WR,   3'd5,       2'b11, 32'hFFFF, 16'h0));
        vecs.push_back(mk(OP_RD,   REG_CTRL,   2'b00, 32'h0,    16'h0101));
        vecs.push_back(mk(OP_RD,   3'd7,       2'b00, 32'h0,    16'h0000));

        reset = 1'b1; tick_in = '0; evt_in = '0; cs = 1'b0; wr = 2'b00; address = '0; din = '0;
        repeat (3) @(negedge clk);
        cs = 1'b1; address = REG_STATUS;
        #1 check("reset dout", {16'b0, dout}, 32'h0);
        check("reset irq", {31'b0, irq}, 32'h0);
        cs = 1'b0;
        reset = 1'b0;
        bus_read(REG_STATUS, rd);
        check("post-reset STATUS", {16'b0, rd}, 32'h8000);
        bus_read(REG_CTRL, rd);
        check("post-reset CTRL", {16'b0, rd}, 32'h0);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_WR: bus_write(vecs[i].addr, vecs[i].data[15:0], vecs[i].wr);
                OP_RD: begin
                    bus_read(vecs[i].addr, rd);
                    check($sformatf("vec%0d read a%0d", i, vecs[i].addr), {16'b0, rd},
                          {16'b0, vecs[i].exp});
                end
                OP_EVT: begin
                    @(negedge clk);
                    evt_in = vecs[i].data[3:0];
                    repeat (8) @(negedge clk);
                end
                OP_TICK: begin
                    @(negedge clk);
                    tick_in = vecs[i].data;
                end
                default: begin
                    @(negedge clk);
                    check($sformatf("vec%0d irq", i), {31'b0, irq}, {31'b0, vecs[i].exp[0]});
                end
            endcase
        end

        // Fill to full, simultaneous push+pop while full, then a dropped 17th entry
        @(negedge clk); evt_in = 4'h0;
        repeat (4) @(negedge clk);
        bus_write(REG_CTRL, 16'h8001, 2'b11);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); tick_in = 32'h100 + 32'(k); evt_in = 4'h1;
            repeat (5) @(negedge clk);
            evt_in = 4'h0;
            repeat (3) @(negedge clk);
        end
        bus_read(REG_STATUS, rd);
        check("full STATUS", {16'b0, rd}, 32'h2010);
        @(negedge clk); tick_in = 32'h200; evt_in = 4'h1;
        repeat (3) @(negedge clk);
        cs = 1'b1; wr = 2'b11; address = REG_HEAD; din = '0;
        @(negedge clk); cs = 1'b0; wr = 2'b00;
        bus_read(REG_STATUS, rd);
        check("full push+pop STATUS", {16'b0, rd}, 32'h2010);
        evt_in = 4'h0;
        repeat (3) @(negedge clk);
        tick_in = 32'h300; evt_in = 4'h1;
        repeat (5) @(negedge clk);
        evt_in = 4'h0;
        repeat (3) @(negedge clk);
        bus_read(REG_STATUS, rd);
        check("overflow STATUS", {16'b0, rd}, 32'h6010);
        for (int k = 1; k <= 16; k++) begin
            bus_read(REG_TS_LO, rd);
            check($sformatf("drain ts %0d", k), {16'b0, rd},
                  (k == 16) ? 32'h200 : 32'h100 + 32'(k));
            bus_write(REG_HEAD, 16'h0, 2'b11);
        end
        bus_read(REG_STATUS, rd);
        check("drained STATUS", {16'b0, rd}, 32'hC000);
        bus_write(REG_CTRL, 16'h8001, 2'b11);
        bus_read(REG_STATUS, rd);
        check("clear STATUS", {16'b0, rd}, 32'h8000);
        bus_read(REG_CTRL, rd);
        check("clear CTRL", {16'b0, rd}, 32'h0001);

        // Capture latency: tick sampled at the second edge after the first sampling edge
        @(negedge clk); evt_in = 4'h1; tick_in = 32'hA0;
        @(negedge clk); tick_in = 32'hA1;
        @(negedge clk); tick_in = 32'hA2;
        @(negedge clk); tick_in = 32'hA3;
        cs = 1'b1; wr = 2'b00; address = REG_STATUS;
        #1 check("latency pre-push", {16'b0, dout}, 32'h8000);
        @(negedge clk);
        #1 check("latency post-push", {16'b0, dout}, 32'h0001);
        cs = 1'b0;
        bus_read(REG_TS_LO, rd);
        check("latency TS_LO", {16'b0, rd}, 32'h00A2);

        // Reset during an in-flight read with a non-empty FIFO
        bus_write(REG_CTRL, 16'h0101, 2'b11);
        @(negedge clk);
        check("pre-reset irq", {31'b0, irq}, 32'h1);
        cs = 1'b1; wr = 2'b00; address = REG_STATUS; reset = 1'b1;
        #1 check("reset in-flight dout", {16'b0, dout}, 32'h0);
        @(negedge clk);
        check("reset irq cleared", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("after reset STATUS", {16'b0, dout}, 32'h8000);
        cs = 1'b0;
        bus_read(REG_CTRL, rd);
        check("after reset CTRL", {16'b0, rd}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/evt_timestamp_unit.md
Name: evt_timestamp_unit

Overview:
- CPU-bus peripheral that timestamps edges on up to 4 asynchronous event inputs: user port pin, core VBlank, HDMI VBlank, gamepad-any-button.
- Each accepted edge pushes the current 32-bit tick count plus a channel ID into a FIFO.
- The 68000 drains the FIFO through 16-bit registers; an optional interrupt output signals "FIFO not empty" to the interrupt-routing logic.
- Upstream of the CPU data mux; gives lag measurement without polling jitter.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 4..256.
- AW, $clog2(DEPTH), FIFO pointer width.
- DEBOUNCE, 16, stable cycles required per edge (optional feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- tick_in  in  32  free-running tick count, already in clk domain.
- evt_in  in  4  raw asynchronous event lines, ch0..ch3.
- cs  in  1  register window select, level for the whole bus cycle.
- wr  in  2  byte write enables {upper, lower}; 0 = read.
- address  in  3  word address.
- din  in  16  write data.
- dout  out  16  read data, combinational from registers.
- irq  out  1  level: FIFO non-empty AND CTRL.irq_en.

Behaviour:
- Reset: dout=0, irq=0, CTRL=0, FIFO empty, overflow=0, pending=0, sync/edge registers=0.
- Registers (word address):
  - 0 CTRL RW: [3:0] ch_en; [7:4] pol (0=rising, 1=falling); [8] irq_en; [15] clear, write-only, reads 0.
  - 1 STATUS RO: [15] empty; [14] overflow sticky; [13] full; [8:0] count.
  - 2 TS_HI RO: head ts[31:16].
  - 3 TS_LO RO: head ts[15:0].
  - 4 HEAD RO: [15] empty, [1:0] head channel. Any write = POP.
  - 5–7: read 0, writes ignored.
- Write qualification:
  - Actions happen once per bus cycle, on the first clk where cs & |wr is seen (rising edge of cs & |wr).
  - Byte lanes honoured for CTRL.
- Input path: 2-flop synchronizer per channel, then edge detect against the previous synced value.
  - Edge accepted only if ch_en[i] and the direction matches pol[i].
  - Disabled channels still track synced value, so enabling never produces a spurious edge.
- Capture: on an accepted edge, the channel's ts register latches tick_in in the same cycle and pending[i] is set.
  - Raw transition first sampled at edge N → capture at edge N+2.
  - Edge on a channel already pending: dropped, overflow set, original timestamp kept.
- Push arbiter: one push per cycle, lowest pending index first; pending[i] cleared on its push.
  - Four simultaneous edges push over 4 consecutive cycles, all with identical ts.
- FIFO full:
  - Push with no pop in the same cycle → entry dropped, pending cleared, overflow set.
  - Push and pop in the same cycle when full → both happen, count unchanged.
- POP on empty: ignored, no underflow, pointers unchanged.
- Clear (CTRL[15]=1): empties FIFO, clears pending and overflow in one cycle; has priority over a same-cycle push.
- Overflow cleared only by Clear or reset.
- Pointers wrap modulo DEPTH; count is AW+1 bits.
- Head reads reflect the new head 1 clk after POP (registered RAM read, prefetched).
- Reset mid-operation: all state returns to reset values the next edge; the in-flight bus cycle completes with dout=0.
- irq follows empty with 1 clk latency after push/pop.

Optional Feature:
- Macro EVT_TS_DEBOUNCE_EN.
- Defined: after the synchronizer each channel has a counter; the filtered level changes only after DEBOUNCE consecutive cycles of a new level. Edge detect and capture use the filtered level, and the timestamp is the tick at filtered transition. Glitches shorter than DEBOUNCE produce no entry.
- Undefined: no counters; synced level feeds edge detect directly; latency as stated above.

Decomposition:
- Package evt_ts_pkg: register address localparams (REG_CTRL..REG_HEAD), CTRL bit positions, typedef evt_entry_t {ch[1:0], ts[31:0]} (34 bits).
- Sub-module evt_ts_fifo: synchronous FIFO of evt_entry_t with push/pop/clear, full/empty/count, show-ahead head output; reused by later capture blocks.

Test Plan:
- CTRL=0x000F; tick_in=0x00001234; rise evt_in[0] → after N+2 capture, STATUS.empty=0, count=1; TS_HI=0x0000, TS_LO=0x1234, HEAD=0x0000; POP → empty=1.
- CTRL=0x00F1 (falling on ch0), pulse ch0 high then low → exactly 1 entry, timestamp at falling edge.
- Rise all 4 channels in the same cycle, tick=0xDEADBEEF → 4 entries, channels 0,1,2,3 in order, all TS=0xDEAD/0xBEEF.
- DEPTH=16: 17 edges without pop → count=16, full=1, overflow=1; the 17th timestamp is absent. Clear → count=0, overflow=0.
- CTRL=0x0101, one edge → irq=1; POP → irq=0 next clk; POP on empty → count stays 0, no pointer change.
- EVT_TS_DEBOUNCE_EN, DEBOUNCE=16: 10-cycle glitch → no entry; 20-cycle high → 1 entry, TS = tick 16 cycles after synced rise.
